// File: rtl/inst_fetch_if.sv
// inst_fetch_if -- signal bundle between the instruction fetch unit and its
// environment (instruction ROM, decode stage, branch unit, control).
//   master : the fetch unit (drives rom_addr, inst_*, fetch_state)
//   slave  : the environment (drives rom_data, enable, inst_ready,
//            redirect_*, halt)
// Optional: FETCH_PERF_CNT_EN adds perf_fetch_count / perf_stall_count.
interface inst_fetch_if;
  logic        enable;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_stall_count;
`endif

  modport master (
    input  enable, rom_data, inst_ready, redirect_valid, redirect_pc, halt,
    output rom_addr, inst_out, inst_pc, inst_valid, fetch_state
`ifdef FETCH_PERF_CNT_EN
    , output perf_fetch_count, perf_stall_count
`endif
  );

  modport slave (
    output enable, rom_data, inst_ready, redirect_valid, redirect_pc, halt,
    input  rom_addr, inst_out, inst_pc, inst_valid, fetch_state
`ifdef FETCH_PERF_CNT_EN
    , input perf_fetch_count, perf_stall_count
`endif
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch -- single-entry instruction fetch stage.
// The pc register addresses a combinational ROM; the returned word is
// captured into a one-deep output slot (inst_out/inst_pc/inst_valid) that
// drains with a valid/ready handshake. Supports redirect (flush + reload pc)
// and halt (stop fetching, drain the slot).
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   fif    - inst_fetch_if.master: rom_addr/rom_data, inst_out/inst_pc/
//            inst_valid/inst_ready, redirect_valid/redirect_pc, halt,
//            enable, fetch_state
// Parameters: RESET_PC (first byte address fetched), ADDR_WIDTH (ROM word
//   address width, only meaningful to the ROM instance).
// Optional macro FETCH_PERF_CNT_EN: transfer and stall counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  inst_fetch_if.master fif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HOLD   = 2'b10,
    HALTED = 2'b11
  } state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // The ROM behind rom_addr cannot exceed the 32-bit byte address space.
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("inst_fetch: ADDR_WIDTH out of range");
  end

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        xfer;
  logic        capture;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    capture      = 1'b0;
    xfer         = inst_valid_q && fif.inst_ready;

    if (fif.redirect_valid) begin
      // A transfer in this cycle has already happened on the bus; the slot
      // is flushed regardless. IDLE only preloads the pc.
      pc_d = {fif.redirect_pc[31:2], 2'b00};
      if (state_q != IDLE) begin
        state_d      = FETCH;
        inst_valid_d = 1'b0;
      end
    end else if (fif.halt && (state_q == FETCH || state_q == HOLD)) begin
      state_d = HALTED;
      if (xfer) inst_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (fif.enable) state_d = FETCH;
        FETCH, HOLD: begin
          // Slot is free or being drained this cycle: refill it.
          if (!inst_valid_q || fif.inst_ready) begin
            capture = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        HALTED: if (xfer) inst_valid_d = 1'b0;
      endcase
    end

    if (capture) begin
      inst_out_d   = fif.rom_data;
      inst_pc_d    = pc_q;
      inst_valid_d = 1'b1;
      pc_d         = pc_q + 32'd4;  // wraps naturally at 2^32
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_ALIGNED;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign fif.rom_addr    = pc_q;
  assign fif.inst_out    = inst_out_q;
  assign fif.inst_pc     = inst_pc_q;
  assign fif.inst_valid  = inst_valid_q;
  assign fif.fetch_state = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count_q, perf_fetch_count_d;
  logic [31:0] perf_stall_count_q, perf_stall_count_d;

  always_comb begin
    perf_fetch_count_d = perf_fetch_count_q + {31'd0, xfer};
    perf_stall_count_d = perf_stall_count_q + {31'd0, inst_valid_q && !fif.inst_ready};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_count_q <= '0;
      perf_stall_count_q <= '0;
    end else begin
      perf_fetch_count_q <= perf_fetch_count_d;
      perf_stall_count_q <= perf_stall_count_d;
    end
  end

  assign fif.perf_fetch_count = perf_fetch_count_q;
  assign fif.perf_stall_count = perf_stall_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch -- directed scenarios followed by randomized traffic, all
// checked against a transaction-level model of the fetch stage.
module tb_inst_fetch;
  logic clock;
  logic reset;
  inst_fetch_if fif();

  inst_fetch #(.RESET_PC(32'h00000000), .ADDR_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .fif   (fif.master)
  );

  logic [31:0] rom [256];
  assign fif.rom_data = rom[fif.rom_addr[9:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode;
  bit          m_stalled;
  logic [31:0] m_pc, m_out, m_ipc;
  logic        m_valid;
  logic [31:0] m_fc, m_sc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_state();
    case (m_mode)
      0:       return 32'd0;
      1:       return m_stalled ? 32'd2 : 32'd1;
      default: return 32'd3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_stalled = 0; m_pc = 32'h0; m_out = 0; m_ipc = 0;
    m_valid = 0; m_fc = 0; m_sc = 0;
  endtask

  task automatic model_step(input logic en, input logic rdy, input logic rv,
                            input logic [31:0] rpc, input logic hl);
    bit xfer;
    xfer = m_valid && rdy;
    if (xfer) m_fc++;
    if (m_valid && !rdy) m_sc++;
    if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      if (m_mode != 0) begin m_mode = 1; m_valid = 0; m_stalled = 0; end
    end else if (hl && m_mode == 1) begin
      m_mode = 2;
      if (xfer) m_valid = 0;
    end else if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_stalled = 0; end
    end else if (m_mode == 1) begin
      if (!m_valid || rdy) begin
        m_out = rom[m_pc[9:2]]; m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 32'd4; m_stalled = 0;
      end else m_stalled = 1;
    end else begin
      if (xfer) m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("inst_valid", {31'd0, fif.inst_valid}, {31'd0, m_valid});
    chk("inst_out", fif.inst_out, m_out);
    chk("inst_pc", fif.inst_pc, m_ipc);
    chk("rom_addr", fif.rom_addr, m_pc);
    chk("fetch_state", {30'd0, fif.fetch_state}, exp_state());
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", fif.perf_fetch_count, m_fc);
    chk("perf_stall", fif.perf_stall_count, m_sc);
`endif
  endtask

  task automatic tick(input logic en, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic hl);
    fif.enable = en; fif.inst_ready = rdy; fif.redirect_valid = rv;
    fif.redirect_pc = rpc; fif.halt = hl;
    model_step(en, rdy, rv, rpc, hl);
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h11111111; rom[1] = 32'h22222222;
    rom[2] = 32'h33333333; rom[3] = 32'h44444444;
    fif.enable = 0; fif.inst_ready = 0; fif.redirect_valid = 0;
    fif.redirect_pc = 0; fif.halt = 0;
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #2 check_all();
    @(posedge clock); #2 reset = 1'b0;
    check_all();

    // No capture without enable after reset release.
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);

    // Straight-line fetch 0..C with ready held.
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0); chk("seq0", fif.inst_out, 32'h11111111);
    tick(1, 1, 0, 0, 0); chk("seq1", fif.inst_out, 32'h22222222);
    tick(1, 1, 0, 0, 0); chk("seq2", fif.inst_out, 32'h33333333);
    tick(1, 1, 0, 0, 0); chk("seq3", fif.inst_out, 32'h44444444);
                         chk("seq3_pc", fif.inst_pc, 32'hC);

    // Backpressure: hold then resume with no gap or duplicate.
    tick(0, 1, 1, 32'h0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    chk("hold_state", {30'd0, fif.fetch_state}, 32'd2);
    chk("hold_out", fif.inst_out, 32'h11111111);
    chk("hold_addr", fif.rom_addr, 32'h4);
    tick(0, 1, 0, 0, 0); chk("resume_out", fif.inst_out, 32'h22222222);

    // Redirect to a misaligned target while valid.
    tick(0, 0, 1, 32'h0000002E, 0);
    chk("redir_valid", {31'd0, fif.inst_valid}, 32'd0);
    chk("redir_addr", fif.rom_addr, 32'h2C);
    tick(0, 1, 0, 0, 0); chk("redir_pc", fif.inst_pc, 32'h2C);

    // Halt with a pending entry, drain it, then resume by redirect.
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("halt_state", {30'd0, fif.fetch_state}, 32'd3);
    chk("halt_held", {31'd0, fif.inst_valid}, 32'd1);
    tick(0, 1, 0, 0, 0); chk("halt_drain", {31'd0, fif.inst_valid}, 32'd0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0); chk("halt_stays", {31'd0, fif.inst_valid}, 32'd0);
    tick(0, 1, 1, 32'h40, 0); chk("halt_exit", {30'd0, fif.fetch_state}, 32'd1);

    // pc wrap, then asynchronous reset in HOLD.
    tick(0, 1, 1, 32'hFFFFFFFC, 0);
    tick(0, 1, 0, 0, 0);
    chk("wrap_addr", fif.rom_addr, 32'h0);
    chk("wrap_pc", fif.inst_pc, 32'hFFFFFFFC);
    tick(0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1 chk("async_valid", {31'd0, fif.inst_valid}, 32'd0);
    chk("async_state", {30'd0, fif.fetch_state}, 32'd0);
    #2 reset = 1'b0;

    // 5 transfers and 3 stall cycles.
    tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf5", fif.perf_fetch_count, 32'd5);
    chk("perf3", fif.perf_stall_count, 32'd3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h3FF);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the byte address fetched first after reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the instruction ROM word-address width, carried for the ROM instance only.
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  start fetching; sampled only in IDLE.
REQ-006 SHALL have port rom_addr  out  32  byte address to the instruction ROM's addr_in.
REQ-007 SHALL have port rom_data  in  32  byte-corrected instruction word from the ROM, combinational on rom_addr.
REQ-008 SHALL have port inst_out  out  32  fetched instruction word.
REQ-009 SHALL have port inst_pc  out  32  byte address of inst_out.
REQ-010 SHALL have port inst_valid  out  1  inst_out/inst_pc hold a valid instruction.
REQ-011 SHALL have port inst_ready  in  1  consumer accepts; transfer = inst_valid && inst_ready.
REQ-012 SHALL have port redirect_valid  in  1  branch/jump redirect request.
REQ-013 SHALL have port redirect_pc  in  32  redirect target byte address.
REQ-014 SHALL have port halt  in  1  stop fetching new instructions.
REQ-015 SHALL have port fetch_state  out  2  current state encoding, for debug.

Function
REQ-016 SHALL drive rom_addr combinationally from the internal pc register, with no added latency.
REQ-017 SHALL implement states IDLE=2'b00, FETCH=2'b01, HOLD=2'b10, HALTED=2'b11.
REQ-018 SHALL apply per-cycle priority: reset > redirect_valid > halt > capture.
REQ-019 In FETCH, when !inst_valid or inst_ready, SHALL capture rom_data into inst_out, pc into inst_pc, set inst_valid=1, and advance pc by 4.
REQ-020 Instruction at pc SHALL appear on inst_out one cycle after pc is on rom_addr; sustained throughput SHALL be one instruction per cycle.
REQ-021 In FETCH, when inst_valid && !inst_ready, SHALL go to HOLD and keep pc, inst_out, inst_pc, inst_valid unchanged.
REQ-022 In HOLD, when inst_ready=1, SHALL complete the transfer, capture the next instruction in the same cycle, and return to FETCH.
REQ-023 In HOLD, when inst_ready=0, SHALL stay in HOLD with all outputs stable.
REQ-024 On redirect_valid in FETCH, HOLD, or HALTED: SHALL set pc={redirect_pc[31:2],2'b00}, clear inst_valid next cycle, capture nothing that cycle, and enter FETCH.
REQ-025 Redirect coincident with a transfer SHALL still count that transfer as completed, then flush.
REQ-026 On redirect_valid in IDLE, SHALL load pc as in REQ-024 and remain in IDLE.
REQ-027 IDLE SHALL go to FETCH when enable=1, with no capture in the transition cycle.
REQ-028 On halt in FETCH or HOLD, SHALL enter HALTED with no capture that cycle.
REQ-029 In HALTED, SHALL hold any valid entry until it transfers, then clear inst_valid.
REQ-030 HALTED SHALL be left only via redirect_valid or reset.
REQ-031 pc increment SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).

Reset
REQ-032 On reset assertion, SHALL set state=IDLE, pc=RESET_PC with bits[1:0] forced to 0, inst_out=0, inst_pc=0, inst_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard any valid entry immediately, without waiting for a clock edge.
REQ-034 On reset release, SHALL NOT capture any instruction until enable is seen in IDLE.

Configuration
REQ-035 With macro FETCH_PERF_CNT_EN defined, SHALL add outputs perf_fetch_count (32) and perf_stall_count (32).
REQ-036 perf_fetch_count SHALL increment on each transfer; perf_stall_count SHALL increment on each cycle with inst_valid && !inst_ready.
REQ-037 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-038 Without FETCH_PERF_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Reset with RESET_PC=0, ROM words 0..3 = 11111111,22222222,33333333,44444444, enable=1 and inst_ready=1 held -> inst_out shows 11111111..44444444 on consecutive cycles with inst_pc 0,4,8,C.
REQ-040 inst_ready=0 for 3 cycles after the first capture -> state=HOLD; inst_out=11111111 and rom_addr=4 stable; after ready rises, 22222222 is delivered with no gap or duplicate.
REQ-041 redirect_valid with redirect_pc=32'h0000002E while valid -> next cycle inst_valid=0 and rom_addr=32'h2C; following cycle inst_pc=32'h2C.
REQ-042 halt=1 with inst_ready=0 -> state=HALTED and the valid entry is held; ready=1 -> transfer, then inst_valid=0 and no further fetches; redirect -> resumes FETCH.
REQ-043 pc forced to 32'hFFFFFFFC via redirect -> after capture, rom_addr=0; reset pulsed mid-HOLD -> inst_valid=0 asynchronously and state=IDLE.
REQ-044 With FETCH_PERF_CNT_EN: 5 transfers plus 3 stall cycles -> perf_fetch_count=5, perf_stall_count=3.
